ifetch_ucode: RTL and testbench

Parametrised instruction-fetch front end with branch folding and a microcode trap sequencer. It drives the instruction-memory address, folds unconditional immediate branches and NOPs out of the stream, and traps the four multiply opcodes into a microcode ROM whose ghost instructions it injects into decode. Output to decode uses a registered valid/ready handshake, so decode back-pressure stalls fetch. Execute-stage redirects override everything.

---
 rtl/ifetch_ucode.sv | 196 +++++++++++++++++++
 tb/tb_ifetch_ucode.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ucode.sv
// Instruction-fetch front end: folds immediate branches and NOPs, traps multiply
// opcodes into a microcode ROM and injects its ghost instructions into decode.
module ifetch_ucode #(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter int unsigned          UCODE_AW    = 6,
    parameter int unsigned          ENTRY_SHIFT = 4,
    parameter bit                   MUL_TRAP_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [31:0]         imem_data,
    output logic [UCODE_AW-1:0] ucode_addr,
    input  logic [32:0]         ucode_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [31:0]         dec_instr,
    output logic [ADDR_W-1:0]   dec_pc,
    output logic                dec_ucode,
    output logic [3:0]          mul_rd,
    output logic [3:0]          mul_rs,
    output logic [15:0]         mul_imm,
    output logic                ucode_busy,
    output logic                ucode_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UCODE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [UCODE_AW-1:0]   upc_q, upc_d;
    logic [ADDR_W-1:0]     trap_pc_q, trap_pc_d;
    logic                  dec_valid_q, dec_valid_d;
    logic [31:0]           dec_instr_q, dec_instr_d;
    logic [ADDR_W-1:0]     dec_pc_q, dec_pc_d;
    logic                  dec_ucode_q, dec_ucode_d;
    logic [3:0]            mul_rd_q, mul_rd_d;
    logic [3:0]            mul_rs_q, mul_rs_d;
    logic [15:0]           mul_imm_q, mul_imm_d;
    logic                  ucode_err_q, ucode_err_d;

    logic                  advance;
    logic [6:0]            op;
    logic                  is_branch;
    logic                  is_nop;
    logic                  is_mul;
    logic signed [63:0]    imm_sx;
    logic [ADDR_W-1:0]     pc_plus4;
    logic [ADDR_W-1:0]     br_target;
    logic [UCODE_AW-1:0]   ucode_entry;
    logic                  upc_at_end;
    logic                  ucode_last;

    assign advance = !dec_valid_q || dec_ready;

    // Instruction classification of the word currently at imem_addr
    always_comb begin
        op          = imem_data[31:25];
        is_branch   = (imem_data[31:30] == 2'b11) && (imem_data[28:25] == 4'b0000);
        is_nop      = (imem_data[31:30] == 2'b11) && (imem_data[28:25] == 4'b0010);
        is_mul      = MUL_TRAP_EN && ((op == 7'b0010000) || (op == 7'b0011000) ||
                                      (op == 7'b0110000) || (op == 7'b0111000));
        imm_sx      = 64'(signed'(imem_data[15:0]));
        pc_plus4    = pc_q + ADDR_W'(4);
        br_target   = pc_plus4 + ADDR_W'(imm_sx <<< 2);
        ucode_entry = UCODE_AW'(32'({op[5], op[3]}) << ENTRY_SHIFT);
        upc_at_end  = &upc_q;
        ucode_last  = ucode_data[32];
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        upc_d       = upc_q;
        trap_pc_d   = trap_pc_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_ucode_d = dec_ucode_q;
        mul_rd_d    = mul_rd_q;
        mul_rs_d    = mul_rs_q;
        mul_imm_d   = mul_imm_q;
        ucode_err_d = ucode_err_q;

        // Redirect wins regardless of back-pressure; the presented instruction
        // (if accepted this cycle) has already been taken by decode.
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            state_d     = FETCH;
            dec_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (advance) begin
                        if (is_branch) begin
                            pc_d        = br_target;
                            dec_valid_d = 1'b0;
                        end else if (is_nop) begin
                            pc_d        = pc_plus4;
                            dec_valid_d = 1'b0;
                        end else if (is_mul) begin
                            mul_rd_d    = imem_data[24:21];
                            mul_rs_d    = imem_data[20:17];
                            mul_imm_d   = imem_data[15:0];
                            trap_pc_d   = pc_q;
                            upc_d       = ucode_entry;
                            pc_d        = pc_plus4;
                            state_d     = UCODE;
                            dec_valid_d = 1'b0;
                        end else begin
                            dec_instr_d = imem_data;
                            dec_pc_d    = pc_q;
                            dec_ucode_d = 1'b0;
                            dec_valid_d = 1'b1;
                            pc_d        = pc_plus4;
                        end
                    end
                end
                UCODE: begin
                    if (advance) begin
                        dec_instr_d = ucode_data[31:0];
                        dec_pc_d    = trap_pc_q;
                        dec_ucode_d = 1'b1;
                        dec_valid_d = 1'b1;
                        if (ucode_last) begin
                            upc_d   = upc_q + UCODE_AW'(1);
                            state_d = FETCH;
                        end else if (upc_at_end) begin
                            // Ran off the ROM: end the sequence here instead of wrapping
                            ucode_err_d = 1'b1;
                            state_d     = FETCH;
                        end else begin
                            upc_d = upc_q + UCODE_AW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            upc_q       <= '0;
            trap_pc_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            dec_ucode_q <= 1'b0;
            mul_rd_q    <= '0;
            mul_rs_q    <= '0;
            mul_imm_q   <= '0;
            ucode_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            upc_q       <= upc_d;
            trap_pc_q   <= trap_pc_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_ucode_q <= dec_ucode_d;
            mul_rd_q    <= mul_rd_d;
            mul_rs_q    <= mul_rs_d;
            mul_imm_q   <= mul_imm_d;
            ucode_err_q <= ucode_err_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ucode_addr = upc_q;
    assign dec_valid  = dec_valid_q;
    assign dec_instr  = dec_instr_q;
    assign dec_pc     = dec_pc_q;
    assign dec_ucode  = dec_ucode_q;
    assign mul_rd     = mul_rd_q;
    assign mul_rs     = mul_rs_q;
    assign mul_imm    = mul_imm_q;
    assign ucode_busy = (state_q == UCODE);
    assign ucode_err  = ucode_err_q;

endmodule

// File: tb/tb_ifetch_ucode.sv
// Bench for ifetch_ucode: an instruction-level program model predicts the decode
// stream; directed phases cover folding, traps, back-pressure, redirect and reset.
module tb_ifetch_ucode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic [31:0] imem_addr, imem_data, redirect_pc, dec_instr, dec_pc;
    logic [5:0]  ucode_addr;
    logic [32:0] ucode_data;
    logic        redirect_valid, dec_valid, dec_ready, dec_ucode, ucode_busy, ucode_err;
    logic [3:0]  mul_rd, mul_rs;
    logic [15:0] mul_imm;

    logic [31:0] imem2_addr, imem2_data, dec2_instr, dec2_pc;
    logic [1:0]  ucode2_addr;
    logic [32:0] ucode2_data;
    logic        dec2_valid, dec2_ucode, ucode2_busy, ucode2_err;
    logic [3:0]  mul2_rd, mul2_rs;
    logic [15:0] mul2_imm;

    logic [31:0] imem [0:127];
    logic [32:0] urom [0:63];
    logic [31:0] imem2 [0:15];
    logic [32:0] urom2 [0:3];

    assign imem_data   = imem[imem_addr[8:2]];
    assign ucode_data  = urom[ucode_addr];
    assign imem2_data  = imem2[imem2_addr[5:2]];
    assign ucode2_data = urom2[ucode2_addr];

    ifetch_ucode #(.ADDR_W(32), .RESET_PC(32'h0), .UCODE_AW(6), .ENTRY_SHIFT(4), .MUL_TRAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .ucode_addr(ucode_addr), .ucode_data(ucode_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_ucode(dec_ucode), .mul_rd(mul_rd), .mul_rs(mul_rs), .mul_imm(mul_imm),
        .ucode_busy(ucode_busy), .ucode_err(ucode_err)
    );

    ifetch_ucode #(.ADDR_W(32), .RESET_PC(32'h0), .UCODE_AW(2), .ENTRY_SHIFT(0), .MUL_TRAP_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst2), .imem_addr(imem2_addr), .imem_data(imem2_data),
        .ucode_addr(ucode2_addr), .ucode_data(ucode2_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(dec2_valid), .dec_ready(1'b1), .dec_instr(dec2_instr), .dec_pc(dec2_pc),
        .dec_ucode(dec2_ucode), .mul_rd(mul2_rd), .mul_rs(mul2_rs), .mul_imm(mul2_imm),
        .ucode_busy(ucode2_busy), .ucode_err(ucode2_err)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        uc;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ghosts2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu(input logic [31:0] a);
        return 32'h0A00_0000 | (a & 32'h0000_FFFF);
    endfunction

    // Architectural walk of the program: what decode must receive, in order
    task automatic gen(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [31:0] ins;
        int unsigned a;
        int pushed;
        int guard;
        bit done;
        exp_t e;
        pc = start;
        pushed = 0;
        guard = 0;
        while (pushed < n && guard < 1000) begin
            guard++;
            ins = imem[pc[8:2]];
            if (ins[31:30] == 2'b11 && ins[28:25] == 4'h0) begin
                pc = pc + 32'd4 + ({{16{ins[15]}}, ins[15:0]} << 2);
            end else if (ins[31:30] == 2'b11 && ins[28:25] == 4'h2) begin
                pc = pc + 32'd4;
            end else if (ins[31:25] == 7'h10 || ins[31:25] == 7'h18 ||
                         ins[31:25] == 7'h30 || ins[31:25] == 7'h38) begin
                a = 32'({ins[30], ins[28]}) * 16;
                done = 1'b0;
                while (!done && pushed < n) begin
                    e = '{urom[a][31:0], pc, 1'b1, ins[24:21], ins[20:17], ins[15:0]};
                    exp_q.push_back(e);
                    pushed++;
                    if (urom[a][32] || a == 63) done = 1'b1;
                    else a++;
                end
                pc = pc + 32'd4;
            end else begin
                e = '{ins, pc, 1'b0, 4'h0, 4'h0, 16'h0};
                exp_q.push_back(e);
                pushed++;
                pc = pc + 32'd4;
            end
        end
    endtask

    // Every presented instruction must be the model's next one; pop on acceptance
    always @(negedge clk) begin
        if (rst && dec_valid) begin
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                chk("dec_out", {dec_ucode, dec_pc, dec_instr}, {cur.uc, cur.pc, cur.instr});
                if (cur.uc)
                    chk("mul_fields", {mul_rd, mul_rs, mul_imm}, {cur.rd, cur.rs, cur.imm});
                if (dec_ready) begin
                    void'(exp_q.pop_front());
                    acc_cyc.push_back(cyc);
                end
            end else if (dec_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got pc %0h instr %0h expected nothing", dec_pc, dec_instr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2) ghosts2 <= 0;
        else if (dec2_valid && dec2_ucode) ghosts2 <= ghosts2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int unsigned k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        chk(nm, exp_q.size(), 0);
        dec_ready = 1'b0;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < 128; i++) imem[i] = alu(i * 4);
        for (int unsigned i = 0; i < 64; i++) urom[i] = {1'b0, 32'h6600_0000 | i};
        for (int unsigned i = 0; i < 16; i++) imem2[i] = alu(i * 4);
        for (int unsigned i = 0; i < 4; i++) urom2[i] = {1'b0, 32'hA000_0000 | i};
        imem[4]    = 32'hC000_FFFE;   // 0x10: B -> 0x0C
        imem[8]    = 32'h306A_0042;   // 0x20: MUL op 0011000 rd=3 rs=5 imm=0x42
        imem[16]   = 32'hC400_0000;   // 0x40: NOP
        imem[18]   = 32'hC400_0000;   // 0x48: NOP
        imem[20]   = 32'hC000_FFFC;   // 0x50: B -> 0x44
        urom[18]   = {1'b1, 32'h6600_0012};
        imem2[0]   = 32'h2000_0000;   // MUL op 0010000, entry 0, no last flag in ROM

        rst = 1'b0; rst2 = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        #2;
        chk("reset_dec", {dec_valid, dec_ucode, dec_pc, dec_instr}, 0);
        chk("reset_mul", {mul_rd, mul_rs, mul_imm}, 0);
        chk("reset_ctl", {ucode_busy, ucode_err, ucode_addr}, 0);
        chk("reset_pc", imem_addr, 32'h0);
        tick(); tick();

        // Sequential stream then branch loop back to 0x0C
        gen(32'h0, 7);
        chk("model_branch_target", exp_q[4].pc, 32'h0C);
        acc_cyc.delete();
        dec_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk("first_edge_no_valid", dec_valid, 1'b0);
        tick();
        chk("second_edge_valid", {dec_valid, dec_pc}, {1'b1, 32'h0});
        drain("drain_seq");
        chk("seq_accept_count", acc_cyc.size(), 7);
        if (acc_cyc.size() >= 7) begin
            chk("seq_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
            chk("branch_bubble", acc_cyc[4] - acc_cyc[3], 2);
            chk("loop_period", acc_cyc[6] - acc_cyc[4], 4);
        end

        // NOP folding loop at 0x40
        redir(32'h40);
        gen(32'h40, 4);
        chk("model_nop_skip", exp_q[0].pc, 32'h44);
        acc_cyc.delete();
        dec_ready = 1'b1;
        drain("drain_nop");
        if (acc_cyc.size() >= 4) chk("nop_loop_timing", acc_cyc[3] - acc_cyc[0], 6);

        // Multiply trap with back-pressure in the middle of the ghost sequence
        redir(32'h20);
        gen(32'h20, 5);
        acc_cyc.delete();
        dec_ready = 1'b1;
        tick();
        chk("trap_entry", {ucode_busy, dec_valid, ucode_addr}, {1'b1, 1'b0, 6'h10});
        chk("trap_latch", {mul_rd, mul_rs, mul_imm}, {4'd3, 4'd5, 16'h0042});
        tick(); tick();
        dec_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("stall_uaddr", ucode_addr, 6'h12);
            chk("stall_instr", {dec_ucode, dec_instr}, {1'b1, 32'h6600_0011});
        end
        dec_ready = 1'b1;
        drain("drain_mul");
        if (acc_cyc.size() >= 4) begin
            chk("stall_gap", acc_cyc[1] - acc_cyc[0], 4);
            chk("ghost_rate", acc_cyc[2] - acc_cyc[1], 1);
            chk("resume_after_ghosts", acc_cyc[3] - acc_cyc[2], 1);
        end

        // Redirect while the second ghost is being accepted
        redir(32'h20);
        gen(32'h20, 2);
        gen(32'h100, 2);
        dec_ready = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("redir_abort", {ucode_busy, dec_valid}, 0);
        chk("redir_ghosts_taken", exp_q.size(), 2);
        drain("drain_redir");

        // Asynchronous reset in the middle of a microcode sequence
        redir(32'h20);
        gen(32'h20, 1);
        dec_ready = 1'b1;
        tick(); tick();
        chk("pre_reset_busy", ucode_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_dec", {dec_valid, dec_ucode, dec_pc, dec_instr}, 0);
        chk("async_rst_mul", {mul_rd, mul_rs, mul_imm}, 0);
        chk("async_rst_ctl", {ucode_busy, ucode_err, ucode_addr}, 0);
        chk("async_rst_pc", imem_addr, 32'h0);
        exp_q.delete();
        tick(); tick();
        gen(32'h0, 2);
        rst = 1'b1;
        tick();
        chk("rerun_first_edge", dec_valid, 1'b0);
        tick();
        chk("rerun_second_edge", {dec_valid, dec_pc}, {1'b1, 32'h0});
        drain("drain_rerun");

        // ROM overrun on the 4-entry instance
        rst2 = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("overrun_not_yet", ucode2_err, 1'b0);
        tick();
        chk("overrun_err", {ucode2_err, ucode2_busy}, {1'b1, 1'b0});
        chk("overrun_last_ghost", {dec2_valid, dec2_ucode, dec2_pc, dec2_instr}, {1'b1, 1'b1, 32'h0, 32'hA000_0003});
        tick();
        chk("overrun_resume", {dec2_valid, dec2_ucode, dec2_pc}, {1'b1, 1'b0, 32'h4});
        chk("overrun_ghost_count", ghosts2, 4);
        repeat (5) tick();
        chk("err_sticky", ucode2_err, 1'b1);
        #2 rst2 = 1'b0;
        #1;
        chk("err_cleared_by_reset", {ucode2_err, dec2_valid, imem2_addr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
